// File: rtl/acc_alu_seq_if.sv
// Operand/command and result/status bundle between the datapath operand
// sources (master) and the accumulator ALU (slave).
interface acc_alu_seq_if #(
   parameter int W = 16
) ();
   logic         start;
   logic [3:0]   opcode;
   logic [W-1:0] input1;
   logic [W-1:0] input2;
   logic [W-1:0] out;
   logic         busy;
   logic         done;
   logic         zero;
   logic         carry;
   logic         ovf;
   logic         dz;
   logic         illegal;

   modport master (
      output start, opcode, input1, input2,
      input  out, busy, done, zero, carry, ovf, dz, illegal
   );

   modport slave (
      input  start, opcode, input1, input2,
      output out, busy, done, zero, carry, ovf, dz, illegal
   );
endinterface

// File: rtl/acc_alu_seq.sv
// W-bit accumulator ALU: one-cycle logic/add/sub, W-cycle shift-add MULT and
// restoring DIV, with start/busy/done handshake and registered status flags.
module acc_alu_seq #(
   parameter int W  = 16,
   parameter int CW = 6
) (
   input  logic         clk,
   input  logic         rst,
   acc_alu_seq_if.slave bus
);

   localparam logic [3:0] OP_NOOP  = 4'b0000;
   localparam logic [3:0] OP_ADD   = 4'b0001;
   localparam logic [3:0] OP_SUB   = 4'b0010;
   localparam logic [3:0] OP_MULT  = 4'b0011;
   localparam logic [3:0] OP_DIV   = 4'b0100;
   localparam logic [3:0] OP_AND   = 4'b0101;
   localparam logic [3:0] OP_OR    = 4'b0110;
   localparam logic [3:0] OP_XOR   = 4'b0111;
   localparam logic [3:0] OP_NOT   = 4'b1000;
   localparam logic [3:0] OP_RESET = 4'b1111;

   localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [2*W-1:0]  prod_q, prod_d;
   logic [W-1:0]    opb_q, opb_d;
   logic [W-1:0]    mplr_q, mplr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            done_q, done_d;
   logic            zero_q, zero_d;
   logic            carry_q, carry_d;
   logic            ovf_q, ovf_d;
   logic            dz_q, dz_d;
   logic            ill_q, ill_d;

   logic [W:0]      add_s;
   logic [W:0]      sub_s;
   logic [W:0]      mul_sum_s;
   logic [2*W-1:0]  mul_next_s;
   logic [W:0]      div_shift_s;
   logic [W:0]      div_diff_s;
   logic            div_ge_s;
   logic [W-1:0]    div_rem_s;
   logic [W-1:0]    div_quot_s;

   // Arithmetic for single-cycle ops and one iteration of each sequencer.
   // In DIV, prod_q holds {remainder, dividend/quotient shift register}.
   always_comb begin
      add_s       = {1'b0, bus.input1} + {1'b0, bus.input2};
      sub_s       = {1'b0, bus.input1} - {1'b0, bus.input2};
      mul_sum_s   = {1'b0, prod_q[2*W-1:W]} +
                    (mplr_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
      mul_next_s  = {mul_sum_s, prod_q[W-1:1]};
      div_shift_s = {prod_q[2*W-1:W], prod_q[W-1]};
      div_diff_s  = div_shift_s - {1'b0, opb_q};
      div_ge_s    = ~div_diff_s[W];
      div_rem_s   = div_ge_s ? div_diff_s[W-1:0] : div_shift_s[W-1:0];
      div_quot_s  = {prod_q[W-2:0], div_ge_s};
   end

   // State and datapath registers; reset aborts any sequence in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= {W{1'b0}};
         prod_q  <= {(2*W){1'b0}};
         opb_q   <= {W{1'b0}};
         mplr_q  <= {W{1'b0}};
         cnt_q   <= {CW{1'b0}};
         done_q  <= 1'b0;
         zero_q  <= 1'b1;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
         opb_q   <= opb_d;
         mplr_q  <= mplr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
         ill_q   <= ill_d;
      end
   end

   // Next-state: accept/decode in IDLE, iterate in MUL/DIV.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      prod_d  = prod_q;
      opb_d   = opb_q;
      mplr_d  = mplr_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      dz_d    = dz_q;
      ill_d   = ill_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               done_d = 1'b1;
               dz_d   = 1'b0;
               ill_d  = 1'b0;
               case (bus.opcode)
                  OP_NOOP: begin
                     acc_d = acc_q;
                  end
                  OP_ADD: begin
                     acc_d   = add_s[W-1:0];
                     carry_d = add_s[W];
                     ovf_d   = 1'b0;
                  end
                  OP_SUB: begin
                     acc_d   = sub_s[W-1:0];
                     carry_d = sub_s[W];
                     ovf_d   = 1'b0;
                  end
                  OP_MULT: begin
                     state_d = ST_MUL;
                     done_d  = 1'b0;
                     prod_d  = {(2*W){1'b0}};
                     opb_d   = bus.input2;
                     mplr_d  = bus.input1;
                     cnt_d   = {CW{1'b0}};
                  end
                  OP_DIV: begin
                     if (bus.input2 == {W{1'b0}}) begin
                        acc_d   = {W{1'b1}};
                        dz_d    = 1'b1;
                        carry_d = 1'b0;
                        ovf_d   = 1'b0;
                     end else begin
                        state_d = ST_DIV;
                        done_d  = 1'b0;
                        prod_d  = {{W{1'b0}}, bus.input1};
                        opb_d   = bus.input2;
                        cnt_d   = {CW{1'b0}};
                     end
                  end
                  OP_AND: begin
                     acc_d   = bus.input1 & bus.input2;
                     carry_d = 1'b0;
                     ovf_d   = 1'b0;
                  end
                  OP_OR: begin
                     acc_d   = bus.input1 | bus.input2;
                     carry_d = 1'b0;
                     ovf_d   = 1'b0;
                  end
                  OP_XOR: begin
                     acc_d   = bus.input1 ^ bus.input2;
                     carry_d = 1'b0;
                     ovf_d   = 1'b0;
                  end
                  OP_NOT: begin
                     acc_d   = ~bus.input1;
                     carry_d = 1'b0;
                     ovf_d   = 1'b0;
                  end
                  OP_RESET: begin
                     acc_d   = {W{1'b0}};
                     carry_d = 1'b0;
                     ovf_d   = 1'b0;
                  end
                  default: begin
                     ill_d = 1'b1;
                  end
               endcase
            end else begin
               done_d = 1'b0;
            end
         end
         ST_MUL: begin
            prod_d = mul_next_s;
            mplr_d = {1'b0, mplr_q[W-1:1]};
            if (cnt_q == LAST_ITER) begin
               state_d = ST_IDLE;
               cnt_d   = {CW{1'b0}};
               acc_d   = mul_next_s[W-1:0];
               ovf_d   = |mul_next_s[2*W-1:W];
               carry_d = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         ST_DIV: begin
            prod_d = {div_rem_s, div_quot_s};
            if (cnt_q == LAST_ITER) begin
               state_d = ST_IDLE;
               cnt_d   = {CW{1'b0}};
               acc_d   = div_quot_s;
               ovf_d   = 1'b0;
               carry_d = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      zero_d = (acc_d == {W{1'b0}});
   end

   // Outputs come straight from registers.
   always_comb begin
      bus.out     = acc_q;
      bus.busy    = (state_q != ST_IDLE);
      bus.done    = done_q;
      bus.zero    = zero_q;
      bus.carry   = carry_q;
      bus.ovf     = ovf_q;
      bus.dz      = dz_q;
      bus.illegal = ill_q;
   end

endmodule

// File: tb/tb_acc_alu_seq.sv
// Directed bench for acc_alu_seq at W=16: vector table for one-cycle ops,
// hand sequences for MULT/DIV timing, busy-ignore, done-cycle accept and reset abort.
module tb_acc_alu_seq;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_fail;

   acc_alu_seq_if #(.W(16)) bus ();

   acc_alu_seq #(.W(16), .CW(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic        c;
      logic        z;
      logic        v;
      logic        d;
      logic        il;
   } vec_t;

   vec_t tv [14];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Launch a multi-cycle op, disturb inputs mid-flight, and check completion.
   task automatic run_multi(input string nm, input logic [3:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [15:0] q, input logic v);
      int n;
      bus.start = 1'b1; bus.opcode = op; bus.input1 = a; bus.input2 = b;
      step();
      bus.start = 1'b0;
      chk({nm, " busy"}, {31'd0, bus.busy}, 32'd1);
      n = 0;
      while (bus.busy && n < 100) begin
         step();
         n++;
         if (n == 5) begin
            bus.start = 1'b1; bus.opcode = 4'b0001;
            bus.input1 = 16'hAAAA; bus.input2 = 16'h5555;
         end
         if (n == 6) bus.start = 1'b0;
      end
      chk({nm, " cycles"}, n, 32'd16);
      chk({nm, " done"}, {31'd0, bus.done}, 32'd1);
      chk({nm, " out"}, {16'd0, bus.out}, {16'd0, q});
      chk({nm, " ovf"}, {31'd0, bus.ovf}, {31'd0, v});
      chk({nm, " zero"}, {31'd0, bus.zero}, {31'd0, (q == 16'h0000)});
   endtask

   initial begin
      n_vec  = 0;
      n_fail = 0;
      //        op       a         b         q         c     z     v     d     il
      tv[0]  = '{4'b0001, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tv[1]  = '{4'b0001, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tv[2]  = '{4'b0010, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tv[3]  = '{4'b0101, 16'h0F0F, 16'hF0F0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tv[4]  = '{4'b0110, 16'h0F0F, 16'hF0F0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tv[5]  = '{4'b0111, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tv[6]  = '{4'b1000, 16'h1234, 16'hFFFF, 16'hEDCB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tv[7]  = '{4'b0010, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tv[8]  = '{4'b0001, 16'h0005, 16'h0000, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tv[9]  = '{4'b1010, 16'h0000, 16'h0000, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tv[10] = '{4'b0000, 16'h0000, 16'h0000, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tv[11] = '{4'b0100, 16'h0007, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tv[12] = '{4'b0000, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tv[13] = '{4'b1111, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

      rst = 1'b1;
      bus.start = 1'b0; bus.opcode = 4'b0000; bus.input1 = 16'h0000; bus.input2 = 16'h0000;
      step();
      rst = 1'b0;
      chk("rst out",   {16'd0, bus.out}, 32'd0);
      chk("rst zero",  {31'd0, bus.zero}, 32'd1);
      chk("rst busy",  {31'd0, bus.busy}, 32'd0);
      chk("rst done",  {31'd0, bus.done}, 32'd0);
      chk("rst flags", {28'd0, bus.carry, bus.ovf, bus.dz, bus.illegal}, 32'd0);

      // Back-to-back one-cycle ops with start held high: done stays high.
      for (int i = 0; i < 14; i++) begin
         bus.start = 1'b1; bus.opcode = tv[i].op; bus.input1 = tv[i].a; bus.input2 = tv[i].b;
         step();
         chk($sformatf("v%0d out", i), {16'd0, bus.out}, {16'd0, tv[i].q});
         chk($sformatf("v%0d flags", i),
             {27'd0, bus.carry, bus.zero, bus.ovf, bus.dz, bus.illegal},
             {27'd0, tv[i].c, tv[i].z, tv[i].v, tv[i].d, tv[i].il});
         chk($sformatf("v%0d done", i), {31'd0, bus.done}, 32'd1);
         chk($sformatf("v%0d busy", i), {31'd0, bus.busy}, 32'd0);
      end
      bus.start = 1'b0;
      step();
      chk("idle done", {31'd0, bus.done}, 32'd0);

      run_multi("mul big", 4'b0011, 16'h0102, 16'h0300, 16'h0600, 1'b1);
      step();
      chk("mul big done fall", {31'd0, bus.done}, 32'd0);
      chk("mul big hold", {16'd0, bus.out}, 32'h0600);

      run_multi("mul small", 4'b0011, 16'h0002, 16'h0002, 16'h0004, 1'b0);
      // Start accepted in the done cycle.
      bus.start = 1'b1; bus.opcode = 4'b0001; bus.input1 = 16'h0004; bus.input2 = 16'h0001;
      step();
      bus.start = 1'b0;
      chk("done-cycle accept out", {16'd0, bus.out}, 32'h0005);
      chk("done-cycle accept done", {31'd0, bus.done}, 32'd1);

      run_multi("div 8/2", 4'b0100, 16'h0008, 16'h0002, 16'h0004, 1'b0);
      run_multi("div 100/7", 4'b0100, 16'h0064, 16'h0007, 16'h000E, 1'b0);
      run_multi("div ffff/3", 4'b0100, 16'hFFFF, 16'h0003, 16'h5555, 1'b0);
      chk("div dz", {31'd0, bus.dz}, 32'd0);

      // Reset in the middle of a DIV.
      bus.start = 1'b1; bus.opcode = 4'b0100; bus.input1 = 16'hFFFF; bus.input2 = 16'h0003;
      step();
      bus.start = 1'b0;
      repeat (8) step();
      chk("abort busy before", {31'd0, bus.busy}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort out",  {16'd0, bus.out}, 32'd0);
      chk("abort busy", {31'd0, bus.busy}, 32'd0);
      chk("abort done", {31'd0, bus.done}, 32'd0);
      chk("abort zero", {31'd0, bus.zero}, 32'd1);
      step();
      chk("abort no done", {31'd0, bus.done}, 32'd0);
      chk("abort still idle", {31'd0, bus.busy}, 32'd0);
      bus.start = 1'b1; bus.opcode = 4'b0101; bus.input1 = 16'h0F0F; bus.input2 = 16'hF0F0;
      step();
      bus.start = 1'b0;
      chk("post-abort and out",  {16'd0, bus.out}, 32'd0);
      chk("post-abort and zero", {31'd0, bus.zero}, 32'd1);
      chk("post-abort and done", {31'd0, bus.done}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
